xor_checksum: RTL and testbench
===============================

XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, 1 or more.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum words per frame, 1 or more.
REQ-003 SHALL have parameter MODE, default 0: 0 = generate checksum, 1 = check frame (last word is the expected checksum).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input word present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-008 SHALL have port in_data, input, WIDTH bits: input word.
REQ-009 SHALL have port in_last, input, 1 bit: the current word ends the frame.
REQ-010 SHALL have port out_valid, output, 1 bit: frame result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_sum, output, WIDTH bits: bitwise XOR of all accepted words in the frame.
REQ-013 SHALL have port out_parity, output, 1 bit: reduction XOR of out_sum.
REQ-014 SHALL have port out_len, output, $clog2(MAX_LEN+1) bits: number of words in the frame.
REQ-015 SHALL have port out_trunc, output, 1 bit: frame closed at MAX_LEN without in_last.
REQ-016 SHALL have port out_err, output, 1 bit: MODE=1 and out_sum is nonzero; always 0 when MODE=0.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM and HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-018 SHALL accept a word only on a cycle where in_valid and in_ready are both high.
REQ-019 On acceptance in IDLE, SHALL set acc=in_data and cnt=1; otherwise remain in IDLE.
REQ-020 On acceptance in ACCUM, SHALL set acc=acc^in_data and cnt=cnt+1.
REQ-021 On an accepted word with in_last=1, SHALL move to HOLD with trunc=0.
REQ-022 On an accepted word with in_last=0 that makes cnt equal MAX_LEN, SHALL move to HOLD with trunc=1; in_last=1 on that same word wins, giving trunc=0.
REQ-023 Otherwise, an accepted word SHALL move IDLE or ACCUM to ACCUM.
REQ-024 If MAX_LEN=1, every frame SHALL be one word; trunc = !in_last.
REQ-025 Latency: out_valid SHALL rise the cycle after the closing word is accepted.
REQ-026 While in HOLD, out_sum/out_parity/out_len/out_trunc/out_err SHALL be taken combinationally from acc/cnt/trunc and held stable until the handshake.
REQ-027 In HOLD with out_ready=1, SHALL return to IDLE next cycle; in_valid in that same cycle SHALL NOT be accepted (in_ready=0).
REQ-028 In HOLD with out_ready=0, SHALL stay in HOLD indefinitely with outputs unchanged.
REQ-029 cnt SHALL never exceed MAX_LEN and SHALL NOT wrap.
REQ-030 Outside HOLD, out_sum, out_len, out_parity, out_trunc and out_err SHALL be 0.

Reset
REQ-031 While rst=1 at a clock edge, SHALL go to IDLE with acc=0, cnt=0, trunc=0, regardless of state or handshake inputs.
REQ-032 After reset, SHALL have in_ready=1 and out_valid=0 on the first cycle after rst falls.
REQ-033 A reset asserted mid-frame or in HOLD SHALL discard the partial frame or result, with no output handshake.

Verification (WIDTH=8, MAX_LEN=4)
REQ-034 Reset: assert rst 2 cycles after accepting 0x12 (no last) -> out_valid=0, in_ready=1; next frame 0x0F(last) gives out_sum=0x0F, out_len=1.
REQ-035 MODE=0: 0x12, 0x34, 0x56(last), out_ready=1 -> one cycle later out_valid=1, out_sum=0x70, out_parity=1, out_len=3, out_trunc=0, out_err=0.
REQ-036 Truncation: 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back, no last -> out_sum=0x04, out_len=4, out_trunc=1; 0x05 stalls until the result handshake, then opens a new frame.
REQ-037 Backpressure: result pending with out_ready=0 for 3 cycles -> out_valid=1, in_ready=0, outputs unchanged; out_ready=1 -> IDLE next cycle.
REQ-038 MODE=1: 0xA5, 0x5A, 0xFF(last) -> out_sum=0x00, out_err=0; same with 0xFE last -> out_sum=0x01, out_err=1.
REQ-039 Single word: 0xC3(last) -> out_sum=0xC3, out_parity=0, out_len=1, out_trunc=0.

Source files
------------

// File: rtl/xor_checksum.sv
// Frame XOR checksum: folds every accepted word of a frame into one word and
// presents it with length, parity, truncation and (in check mode) error flags.
module xor_checksum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int MODE    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_sum,
  output logic                           out_parity,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_len,
  output logic                           out_trunc,
  output logic                           out_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              trunc_q, trunc_d;

  logic [WIDTH-1:0]  acc_nxt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // The first word of a frame replaces the accumulator; cnt never passes
  // MAX_LEN because reaching it always closes the frame.
  always_comb begin
    acc_nxt = (state_q == ACCUM) ? (acc_q ^ in_data) : in_data;
    cnt_nxt = (state_q == ACCUM) ? (cnt_q + LEN_W'(1)) : LEN_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          if (in_last || (cnt_nxt == MAX_CNT)) begin
            state_d = HOLD;
            trunc_d = !in_last;
          end else begin
            state_d = ACCUM;
            trunc_d = 1'b0;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result fields are only visible while a frame result is being offered.
  assign hold       = (state_q == HOLD);
  assign out_sum    = hold ? acc_q : '0;
  assign out_parity = ^out_sum;
  assign out_len    = hold ? cnt_q : '0;
  assign out_trunc  = hold & trunc_q;
  assign out_err    = (MODE == 1) && hold && (|acc_q);

endmodule

// File: tb/tb_xor_checksum.sv
// Bench for xor_checksum: a generate-mode and a check-mode instance share the
// same stimulus; directed vectors plus randomized traffic against a frame model.
module tb_xor_checksum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [WIDTH-1:0] in_data;

  logic rdy0, rdy1, vld0, vld1, par0, par1, trc0, trc1, err0, err1;
  logic [WIDTH-1:0] sum0, sum1;
  logic [LW-1:0] len0, len1;

  xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .MODE(0)) u_gen (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0),
    .out_parity(par0), .out_len(len0), .out_trunc(trc0), .out_err(err0));

  xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .MODE(1)) u_chk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1),
    .out_parity(par1), .out_len(len1), .out_trunc(trc1), .out_err(err1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: words of the open frame kept in a queue, plus the
  // one result waiting for the consumer.
  logic [WIDTH-1:0] m_words[$];
  bit               m_pend;
  logic [WIDTH-1:0] m_sum;
  int               m_len;
  bit               m_trunc;

  task automatic check_model();
    logic [WIDTH-1:0] es;
    es = m_pend ? m_sum : '0;
    check("m_in_ready_gen", rdy0, !m_pend);
    check("m_in_ready_chk", rdy1, !m_pend);
    check("m_out_valid_gen", vld0, m_pend);
    check("m_out_valid_chk", vld1, m_pend);
    check("m_sum_gen", sum0, es);
    check("m_sum_chk", sum1, es);
    check("m_parity", par0, $countones(es) % 2);
    check("m_len", len0, m_pend ? m_len : 0);
    check("m_trunc", trc0, m_pend && m_trunc);
    check("m_err_gen", err0, 0);
    check("m_err_chk", err1, m_pend && (es != 0));
  endtask

  task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] d,
                            input bit l, input bit ordy);
    if (r) begin
      m_words.delete();
      m_pend = 0;
    end else if (m_pend) begin
      if (ordy) m_pend = 0;
    end else if (v) begin
      m_words.push_back(d);
      if (l || m_words.size() == MAX_LEN) begin
        m_sum = '0;
        foreach (m_words[i]) m_sum ^= m_words[i];
        m_len   = m_words.size();
        m_trunc = !l;
        m_pend  = 1;
        m_words.delete();
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] d,
                       input bit l, input bit ordy);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    check_model();
    model_step(r, v, d, l, ordy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit               v;
    logic [WIDTH-1:0] d;
    bit               l;
    bit               ordy;
    bit               ev;
    bit               er;
    logic [WIDTH-1:0] esum;
    int               elen;
    bit               etr;
    bit               eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit ordy,
                     input bit ev, input bit er, input logic [WIDTH-1:0] esum,
                     input int elen, input bit etr, input bit eerr);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.ordy = ordy;
    t.ev = ev; t.er = er; t.esum = esum; t.elen = elen; t.etr = etr; t.eerr = eerr;
    tbl.push_back(t);
  endtask

  initial begin
    // Rows: inputs applied this cycle, outputs expected before this cycle's edge.
    add(1, 8'h12, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h34, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h56, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'h70, 3, 0, 1);
    add(0, 8'h00, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h01, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h02, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h03, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h04, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h05, 0, 0,  1, 0, 8'h04, 4, 1, 1);
    add(1, 8'h05, 0, 0,  1, 0, 8'h04, 4, 1, 1);
    add(1, 8'h05, 0, 0,  1, 0, 8'h04, 4, 1, 1);
    add(1, 8'h05, 0, 1,  1, 0, 8'h04, 4, 1, 1);
    add(1, 8'h05, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'hFA, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'hFF, 2, 0, 1);
    add(1, 8'hA5, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h5A, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'hFF, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'h00, 3, 0, 0);
    add(1, 8'hA5, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h5A, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'hFE, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'h01, 3, 0, 1);
    add(1, 8'hC3, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'hC3, 1, 0, 1);
    add(1, 8'h11, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h22, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h33, 0, 1,  0, 1, 8'h00, 0, 0, 0);
    add(1, 8'h44, 1, 1,  0, 1, 8'h00, 0, 0, 0);
    add(0, 8'h00, 0, 1,  1, 0, 8'h44, 4, 0, 1);
    add(0, 8'h00, 0, 1,  0, 1, 8'h00, 0, 0, 0);

    rst = 1; in_valid = 1; in_data = 8'hEE; in_last = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    m_words.delete();
    m_pend = 0;
    rst = 0; in_valid = 0;
    check("reset_in_ready", rdy0, 1);
    check("reset_out_valid", vld0, 0);
    check("reset_sum", sum0, 0);
    check("reset_len", len0, 0);

    foreach (tbl[i]) begin
      rst = 0; in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      out_ready = tbl[i].ordy;
      check($sformatf("tbl%0d_out_valid", i), vld0, tbl[i].ev);
      check($sformatf("tbl%0d_in_ready", i), rdy0, tbl[i].er);
      check($sformatf("tbl%0d_sum", i), sum0, tbl[i].esum);
      check($sformatf("tbl%0d_parity", i), par0, $countones(tbl[i].esum) % 2);
      check($sformatf("tbl%0d_len", i), len0, tbl[i].elen);
      check($sformatf("tbl%0d_trunc", i), trc0, tbl[i].etr);
      check($sformatf("tbl%0d_err_chk", i), err1, tbl[i].eerr);
      check($sformatf("tbl%0d_err_gen", i), err0, 0);
      cycle(0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
    end

    // Reset two cycles into a partial frame, with a word offered during reset.
    cycle(0, 1, 8'h12, 0, 1);
    cycle(0, 0, 8'h00, 0, 1);
    cycle(0, 0, 8'h00, 0, 1);
    cycle(1, 1, 8'h55, 0, 1);
    check("midrst_out_valid", vld0, 0);
    check("midrst_in_ready", rdy0, 1);
    cycle(0, 1, 8'h0F, 1, 0);
    check("midrst_next_valid", vld0, 1);
    check("midrst_next_sum", sum0, 8'h0F);
    check("midrst_next_len", len0, 1);
    // Reset while a result is held discards it without a handshake.
    cycle(1, 0, 8'h00, 0, 0);
    check("holdrst_out_valid", vld0, 0);
    check("holdrst_in_ready", rdy0, 1);
    check("holdrst_sum", sum0, 0);

    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            WIDTH'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    check_model();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
